bus_dev_port: RTL and testbench

Device-side endpoint of the shared bus generated by `bs_gnrtr`: one instance per device slot. It buffers outbound packets from local logic and presents them to the bus through the `pndng`/`D_pop`/`pop` pull interface. It accepts inbound `push`/`D_push` deliveries from the bus, filters them by destination ID, and queues them for local logic on a valid/ready interface.

---
 rtl/bus_dev_port_if.sv | 34 +++
 rtl/bus_dev_port.sv | 134 +++++++++++++
 tb/tb_bus_dev_port.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_dev_port_if.sv
// Bus/local-side signal bundle for one bus_dev_port device slot.
// master: the bus plus local logic driving the port; slave: the port itself.
interface bus_dev_port_if #(
  parameter int unsigned pckg_sz = 16
);
  // Local logic -> TX FIFO
  logic [pckg_sz-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  // TX FIFO -> bus pull interface
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  // Bus -> RX FIFO
  logic               push;
  logic [pckg_sz-1:0] D_push;
  // RX FIFO -> local logic
  logic [pckg_sz-1:0] rx_data;
  logic               rx_valid;
  logic               rx_ready;
  // Status
  logic [7:0]         rx_drop_cnt;
  logic               pop_err;

  modport master (
    output tx_data, tx_valid, pop, push, D_push, rx_ready,
    input  tx_ready, pndng, D_pop, rx_data, rx_valid, rx_drop_cnt, pop_err
  );

  modport slave (
    input  tx_data, tx_valid, pop, push, D_push, rx_ready,
    output tx_ready, pndng, D_pop, rx_data, rx_valid, rx_drop_cnt, pop_err
  );
endinterface

// File: rtl/bus_dev_port.sv
// Device-side bus endpoint: TX FIFO feeding the bus pull interface, RX FIFO
// filled from bus pushes (optionally filtered by destination ID).
// Build option: define BUS_DEV_PORT_ADDR_FILTER_EN to enable the RX address
// check; otherwise every push is accepted.
module bus_dev_port #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input logic           clk,
  input logic           reset,
  bus_dev_port_if.slave bus_if
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(depth);
`ifdef BUS_DEV_PORT_ADDR_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  // Reset-release synchroniser; traffic is honoured once sync_q[1] is set.
  logic [1:0] sync_q, sync_d;
  logic       active;

  logic [PtrW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [PtrW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]      drop_q, drop_d;
  logic            pop_err_q, pop_err_d;

  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];

  logic       tx_pndng, tx_rdy, tx_wr, tx_rd;
  logic       rx_has, rx_full, rx_hit, rx_accept, rx_wr, rx_rd, rx_drop;
  logic [7:0] rx_dest;

  // Occupancy-derived status and the qualified read/write strobes.
  always_comb begin
    sync_d    = {sync_q[0], 1'b1};
    active    = sync_q[1];
    tx_pndng  = (tx_cnt_q != '0);
    tx_rdy    = (tx_cnt_q != FullCnt);
    tx_wr     = active && bus_if.tx_valid && tx_rdy;
    tx_rd     = active && bus_if.pop && tx_pndng;
    rx_has    = (rx_cnt_q != '0);
    rx_full   = (rx_cnt_q == FullCnt);
    rx_dest   = bus_if.D_push[pckg_sz-1 -: 8];
    rx_hit    = (rx_dest == id) || (rx_dest == broadcast);
    rx_accept = active && bus_if.push && (!FilterEn || rx_hit);
    rx_rd     = active && rx_has && bus_if.rx_ready;
    // A full RX can still take a push when local logic frees a slot this cycle.
    rx_wr     = rx_accept && (!rx_full || rx_rd);
    rx_drop   = rx_accept && rx_full && !rx_rd;
  end

  // Next-state for both FIFOs' pointers/counts and the status registers.
  always_comb begin
    tx_wr_ptr_d = tx_wr ? tx_wr_ptr_q + PtrW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd ? tx_rd_ptr_q + PtrW'(1) : tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_wr && !tx_rd) begin
      tx_cnt_d = tx_cnt_q + CntW'(1);
    end else if (!tx_wr && tx_rd) begin
      tx_cnt_d = tx_cnt_q - CntW'(1);
    end

    rx_wr_ptr_d = rx_wr ? rx_wr_ptr_q + PtrW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd ? rx_rd_ptr_q + PtrW'(1) : rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_wr && !rx_rd) begin
      rx_cnt_d = rx_cnt_q + CntW'(1);
    end else if (!rx_wr && rx_rd) begin
      rx_cnt_d = rx_cnt_q - CntW'(1);
    end

    drop_d = drop_q;
    if (rx_drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    pop_err_d = pop_err_q | (active && bus_if.pop && !tx_pndng);
  end

  // Control state; asynchronous reset discards all queued packets at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      drop_q      <= '0;
      pop_err_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      drop_q      <= drop_d;
      pop_err_q   <= pop_err_d;
    end
  end

  // Packet storage; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk) begin
    if (tx_wr) begin
      tx_mem_q[tx_wr_ptr_q] <= bus_if.tx_data;
    end
    if (rx_wr) begin
      rx_mem_q[rx_wr_ptr_q] <= bus_if.D_push;
    end
  end

  // Heads are forced to zero when empty so stale storage never leaks out.
  assign bus_if.tx_ready    = tx_rdy;
  assign bus_if.pndng       = tx_pndng;
  assign bus_if.D_pop       = tx_pndng ? tx_mem_q[tx_rd_ptr_q] : '0;
  assign bus_if.rx_valid    = rx_has;
  assign bus_if.rx_data     = rx_has ? rx_mem_q[rx_rd_ptr_q] : '0;
  assign bus_if.rx_drop_cnt = drop_q;
  assign bus_if.pop_err     = pop_err_q;

endmodule

// File: tb/tb_bus_dev_port.sv
// Randomised + directed bench for bus_dev_port with a queue-based reference model.
module tb_bus_dev_port;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 8;
  localparam logic [7:0]  ID    = 8'h02;
`ifdef BUS_DEV_PORT_ADDR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_dev_port_if #(.pckg_sz(W)) bif ();

  bus_dev_port #(
    .pckg_sz  (W),
    .depth    (DEPTH),
    .id       (ID),
    .broadcast(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bif)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_tx[$];
  logic [W-1:0] m_rx[$];
  int           m_drop   = 0;
  bit           m_poperr = 1'b0;
  int           m_sync   = 0;

  function automatic bit addr_ok(input logic [W-1:0] p);
    return !FILT || (p[W-1 -: 8] == ID) || (p[W-1 -: 8] == 8'hFF);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_tx.delete();
      m_rx.delete();
      m_drop   = 0;
      m_poperr = 1'b0;
      m_sync   = 0;
    end else begin
      bit act, tfull, rfull, rd;
      act = (m_sync >= 2);
      if (m_sync < 2) m_sync++;
      if (act) begin
        tfull = (m_tx.size() == DEPTH);
        if (bif.pop) begin
          if (m_tx.size() == 0) m_poperr = 1'b1;
          else void'(m_tx.pop_front());
        end
        if (bif.tx_valid && !tfull) m_tx.push_back(bif.tx_data);

        rfull = (m_rx.size() == DEPTH);
        rd    = bif.rx_ready && (m_rx.size() != 0);
        if (rd) void'(m_rx.pop_front());
        if (bif.push && addr_ok(bif.D_push)) begin
          if (!rfull || rd) m_rx.push_back(bif.D_push);
          else if (m_drop < 255) m_drop++;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("pndng",    {31'd0, bif.pndng},    {31'd0, m_tx.size() != 0});
      chk("tx_ready", {31'd0, bif.tx_ready}, {31'd0, m_tx.size() != DEPTH});
      chk("D_pop",    {16'd0, bif.D_pop},    (m_tx.size() != 0) ? {16'd0, m_tx[0]} : 32'd0);
      chk("rx_valid", {31'd0, bif.rx_valid}, {31'd0, m_rx.size() != 0});
      chk("rx_data",  {16'd0, bif.rx_data},  (m_rx.size() != 0) ? {16'd0, m_rx[0]} : 32'd0);
      chk("drop_cnt", {24'd0, bif.rx_drop_cnt}, 32'(m_drop));
      chk("pop_err",  {31'd0, bif.pop_err},  {31'd0, m_poperr});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bif.tx_valid = 1'b0;
    bif.tx_data  = '0;
    bif.pop      = 1'b0;
    bif.push     = 1'b0;
    bif.D_push   = '0;
    bif.rx_ready = 1'b0;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] r;
      logic [7:0]  dest;
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       dest = ID;
        1:       dest = 8'hFF;
        default: dest = r[31:24];
      endcase
      bif.tx_valid = ($urandom_range(0, 99) < 55);
      bif.tx_data  = r[15:0];
      bif.pop      = ($urandom_range(0, 99) < 45);
      bif.push     = ($urandom_range(0, 99) < 60);
      bif.D_push   = {dest, r[23:16]};
      bif.rx_ready = ($urandom_range(0, 99) < 35);
      tick();
    end
    idle_inputs();
  endtask

  task automatic release_reset();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    logic [W-1:0] exp_rx[$];
    idle_inputs();
    #1 reset = 1'b0;
    check_en = 1'b1;
    repeat (2) tick();

    // Reset values
    chk("rst_pndng",    {31'd0, bif.pndng},       32'd0);
    chk("rst_tx_ready", {31'd0, bif.tx_ready},    32'd1);
    chk("rst_D_pop",    {16'd0, bif.D_pop},       32'd0);
    chk("rst_rx_valid", {31'd0, bif.rx_valid},    32'd0);
    chk("rst_drop",     {24'd0, bif.rx_drop_cnt}, 32'd0);
    tick();
    release_reset();

    // TX order: three writes, then one pop per cycle
    bif.tx_valid = 1'b1; bif.tx_data = 16'h0011; tick();
    bif.tx_data = 16'h0122; tick();
    bif.tx_data = 16'h0233; tick();
    bif.tx_valid = 1'b0;
    chk("txo_0", {16'd0, bif.D_pop}, 32'h0011);
    bif.pop = 1'b1; tick();
    chk("txo_1", {16'd0, bif.D_pop}, 32'h0122);
    tick();
    chk("txo_2", {16'd0, bif.D_pop}, 32'h0233);
    tick();
    bif.pop = 1'b0;
    chk("txo_empty", {31'd0, bif.pndng}, 32'd0);

    // TX full, refused 9th write, then simultaneous write+pop at count 7
    bif.tx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bif.tx_data = 16'hA000 + 16'(i);
      tick();
    end
    bif.tx_valid = 1'b0;
    chk("full_ready", {31'd0, bif.tx_ready}, 32'd0);
    chk("full_head",  {16'd0, bif.D_pop},    32'hA000);
    bif.pop = 1'b1; tick();
    bif.tx_valid = 1'b1; bif.tx_data = 16'hB007; tick();
    bif.tx_valid = 1'b0; bif.pop = 1'b0;
    chk("cnt7_ready", {31'd0, bif.tx_ready}, 32'd1);
    chk("cnt7_head",  {16'd0, bif.D_pop},    32'hA002);
    bif.pop = 1'b1;
    repeat (7) tick();
    bif.pop = 1'b0;
    chk("drain_pndng", {31'd0, bif.pndng}, 32'd0);

    // RX address filter
    bif.push = 1'b1;
    bif.D_push = 16'h0255; tick();
    bif.D_push = 16'h0366; tick();
    bif.D_push = 16'hFF77; tick();
    bif.push = 1'b0;
    exp_rx.push_back(16'h0255);
    if (!FILT) exp_rx.push_back(16'h0366);
    exp_rx.push_back(16'hFF77);
    bif.rx_ready = 1'b1;
    foreach (exp_rx[k]) begin
      chk("rx_filter", {16'd0, bif.rx_data}, {16'd0, exp_rx[k]});
      tick();
    end
    bif.rx_ready = 1'b0;
    chk("rx_filter_empty", {31'd0, bif.rx_valid}, 32'd0);

    // RX overflow: 10 pushes, 8 stored, 2 dropped
    bif.push = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bif.D_push = 16'h0200 + 16'(i);
      tick();
    end
    chk("drop_2", {24'd0, bif.rx_drop_cnt}, 32'd2);
    bif.D_push = 16'h02EE; bif.rx_ready = 1'b1; tick();
    bif.push = 1'b0;
    chk("drop_still_2", {24'd0, bif.rx_drop_cnt}, 32'd2);
    chk("rx_head_after", {16'd0, bif.rx_data}, 32'h0201);
    repeat (8) tick();
    bif.rx_ready = 1'b0;
    chk("rx_drained", {31'd0, bif.rx_valid}, 32'd0);

    // Pop while empty sets sticky error
    bif.pop = 1'b1; tick();
    bif.pop = 1'b0;
    chk("pop_err_set", {31'd0, bif.pop_err}, 32'd1);

    random_cycles(1500);
    chk("pop_err_sticky", {31'd0, bif.pop_err}, 32'd1);

    // Drain, load TX with 4 packets, then assert reset between edges
    bif.pop = 1'b1; bif.rx_ready = 1'b1;
    repeat (10) tick();
    idle_inputs();
    bif.tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bif.tx_data = 16'hC000 + 16'(i);
      tick();
    end
    bif.tx_valid = 1'b0;
    chk("pre_rst_pndng", {31'd0, bif.pndng}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_pndng",   {31'd0, bif.pndng},    32'd0);
    chk("async_pop_err", {31'd0, bif.pop_err},  32'd0);
    chk("async_D_pop",   {16'd0, bif.D_pop},    32'd0);
    chk("async_ready",   {31'd0, bif.tx_ready}, 32'd1);
    tick();
    tick();
    release_reset();

    random_cycles(800);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
